// File: rtl/pp_pkg.sv
// Shared types and defaults for the preprocess row reader.
// FSM encodings, default geometry and the DRAIN timeout.
package pp_pkg;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } pp_state_e;

   localparam int PP_DATA_WIDTH = 12;
   localparam int PP_LINE_WIDTH = 640;
   localparam int PP_FRAME_ROWS = 480;
   localparam int DRAIN_TIMEOUT = 2;

endpackage

// File: rtl/pp_pos_counter.sv
// Column/row position counter: column steps on i_col_en, row steps (and column clears) on i_row_en.
// Latency 1 cycle; no backpressure, both counters wrap to 0.
module pp_pos_counter #(
   parameter int COL_MAX = 640,
   parameter int ROW_MAX = 480,
   parameter int COL_W   = 10,
   parameter int ROW_W   = 9
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_clr,
   input  logic             i_col_en,
   input  logic             i_row_en,
   output logic [COL_W-1:0] o_col,
   output logic [ROW_W-1:0] o_row,
   output logic             o_last_col,
   output logic             o_last_row
);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   assign o_last_col = (col_q == COL_W'(COL_MAX - 1));
   assign o_last_row = (row_q == ROW_W'(ROW_MAX - 1));
   assign o_col      = col_q;
   assign o_row      = row_q;

   // Closing a row wins over a pixel landing in the same cycle.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (i_row_en) begin
         col_d = '0;
         row_d = o_last_row ? '0 : row_q + ROW_W'(1);
      end else if (i_col_en) begin
         col_d = o_last_col ? '0 : col_q + COL_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn || i_clr) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/pp_row_reader.sv
// Row reader: waits for a full buffered row plus downstream ready, bursts LINE_WIDTH reads, frames the returned pixels.
// Optional sticky underrun flag when PP_ROW_READER_UNDERRUN_EN is defined.
module pp_row_reader
   import pp_pkg::*;
#(
   parameter int DATA_WIDTH = PP_DATA_WIDTH,
   parameter int FILL_WIDTH = 11,
   parameter int LINE_WIDTH = PP_LINE_WIDTH,
   parameter int FRAME_ROWS = PP_FRAME_ROWS,
   parameter int COL_W      = 10,
   parameter int ROW_W      = 9
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   output logic                  o_rd,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic [FILL_WIDTH-1:0] i_fill,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_sol,
   output logic                  o_eol,
   output logic                  o_sof,
   output logic                  o_eof,
   output logic [COL_W-1:0]      o_col,
   output logic [ROW_W-1:0]      o_row,
   output logic                  o_busy
`ifdef PP_ROW_READER_UNDERRUN_EN
  ,output logic                  o_underrun
`endif
);

   localparam logic [FILL_WIDTH-1:0] LW_FILL  = FILL_WIDTH'(LINE_WIDTH);
   localparam logic [COL_W-1:0]      LAST_ISS = COL_W'(LINE_WIDTH - 1);
   localparam logic [1:0]            DRN_LAST = 2'(DRAIN_TIMEOUT - 1);

   pp_state_e        state_q, state_d;
   logic             rd_q, rd_d;
   logic [COL_W-1:0] iss_q, iss_d;
   logic [1:0]       drn_q, drn_d;
   logic             rx_done_q, rx_done_d;
   logic             row_close;
   logic             accept;
   logic             clr;

   logic [COL_W-1:0] pos_col;
   logic [ROW_W-1:0] pos_row;
   logic             last_col, last_row;

   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q, sol_q, eol_q, sof_q, eof_q;
   logic [COL_W-1:0]      col_q;
   logic [ROW_W-1:0]      row_q;

   assign clr    = !i_rstn || i_flush;
   // Data returning while idle belongs to an aborted row and is dropped.
   assign accept = i_valid && ((state_q == ST_BURST) || (state_q == ST_DRAIN));

   pp_pos_counter #(
      .COL_MAX (LINE_WIDTH),
      .ROW_MAX (FRAME_ROWS),
      .COL_W   (COL_W),
      .ROW_W   (ROW_W)
   ) u_pos (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_clr      (i_flush),
      .i_col_en   (accept),
      .i_row_en   (row_close),
      .o_col      (pos_col),
      .o_row      (pos_row),
      .o_last_col (last_col),
      .o_last_row (last_row)
   );

   always_comb begin
      state_d   = state_q;
      rd_d      = 1'b0;
      iss_d     = iss_q;
      drn_d     = drn_q;
      rx_done_d = rx_done_q;
      row_close = 1'b0;
      if (accept && last_col) begin
         rx_done_d = 1'b1;
      end
      case (state_q)
         ST_WAIT: begin
            iss_d = '0;
            drn_d = '0;
            if ((i_fill >= LW_FILL) && i_ready) begin
               state_d = ST_BURST;
               rd_d    = 1'b1;
            end
         end
         ST_BURST: begin
            rd_d  = 1'b1;
            iss_d = iss_q + COL_W'(1);
            drn_d = '0;
            if (iss_q == LAST_ISS) begin
               rd_d    = 1'b0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            drn_d = drn_q + 2'd1;
            // A short row is closed anyway so the frame keeps moving.
            if (rx_done_q || (drn_q == DRN_LAST)) begin
               row_close = 1'b1;
               rx_done_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (clr) begin
         state_q   <= ST_WAIT;
         rd_q      <= 1'b0;
         iss_q     <= '0;
         drn_q     <= '0;
         rx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         iss_q     <= iss_d;
         drn_q     <= drn_d;
         rx_done_q <= rx_done_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (clr) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         sol_q   <= 1'b0;
         eol_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else if (accept) begin
         data_q  <= i_data;
         valid_q <= 1'b1;
         sol_q   <= (pos_col == '0);
         eol_q   <= last_col;
         sof_q   <= (pos_col == '0) && (pos_row == '0);
         eof_q   <= last_col && last_row;
         col_q   <= pos_col;
         row_q   <= pos_row;
      end else begin
         valid_q <= 1'b0;
         sol_q   <= 1'b0;
         eol_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
      end
   end

`ifdef PP_ROW_READER_UNDERRUN_EN
   logic und_q;

   always_ff @(posedge i_clk) begin
      if (clr) begin
         und_q <= 1'b0;
      end else if ((state_q == ST_DRAIN) && !rx_done_q && (drn_q == DRN_LAST)) begin
         und_q <= 1'b1;
      end
   end

   assign o_underrun = und_q;
`endif

   assign o_rd    = rd_q;
   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_sol   = sol_q;
   assign o_eol   = eol_q;
   assign o_sof   = sof_q;
   assign o_eof   = eof_q;
   assign o_col   = col_q;
   assign o_row   = row_q;
   assign o_busy  = (state_q == ST_BURST) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pp_row_reader.sv
// Bench for pp_row_reader with an 8-pixel, 2-row frame; FIFO responder and framed-stream reference model.
// Underrun flag checks are active when PP_ROW_READER_UNDERRUN_EN is defined.
module tb_pp_row_reader;

   localparam int DW   = 12;
   localparam int FW   = 5;
   localparam int LW   = 8;
   localparam int ROWS = 2;
   localparam int CW   = 3;
   localparam int RW   = 1;

   logic          i_clk   = 1'b0;
   logic          i_rstn  = 1'b0;
   logic          i_flush = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ready = 1'b0;
   logic [DW-1:0] i_data  = '0;
   logic [FW-1:0] i_fill  = '0;
   logic          o_rd, o_valid, o_sol, o_eol, o_sof, o_eof, o_busy;
   logic [DW-1:0] o_data;
   logic [CW-1:0] o_col;
   logic [RW-1:0] o_row;
`ifdef PP_ROW_READER_UNDERRUN_EN
   logic          o_underrun;
`endif

   always #5 i_clk = ~i_clk;

   pp_row_reader #(
      .DATA_WIDTH (DW),
      .FILL_WIDTH (FW),
      .LINE_WIDTH (LW),
      .FRAME_ROWS (ROWS),
      .COL_W      (CW),
      .ROW_W      (RW)
   ) dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_flush (i_flush),
      .o_rd    (o_rd),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_fill  (i_fill),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_sol   (o_sol),
      .o_eol   (o_eol),
      .o_sof   (o_sof),
      .o_eof   (o_eof),
      .o_col   (o_col),
      .o_row   (o_row),
      .o_busy  (o_busy)
`ifdef PP_ROW_READER_UNDERRUN_EN
     ,.o_underrun (o_underrun)
`endif
   );

   typedef struct {
      logic [DW-1:0] dat;
      int            col;
      int            row;
      int            due;
   } exp_t;

   exp_t          expq[$];
   logic [DW-1:0] fifo[$];

   int tests_run     = 0;
   int tests_failed  = 0;
   int cyc           = 0;
   int strobe_idx    = 0;
   int rcv_col       = 0;
   int model_row     = 0;
   int run           = 0;
   int dphase        = 0;
   int bursts        = 0;
   int withhold_idx  = -1;
   int strobe_seen   = -1;
   int strobes_total = 0;
   logic          pend_vld = 1'b0;
   logic [DW-1:0] pend_dat = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock of the world: check outputs, answer reads like the FIFO, drive the next inputs.
   task automatic tick();
      logic          ok;
      logic          nvld;
      logic [DW-1:0] ndat;
      exp_t          e;
      @(negedge i_clk);
      cyc++;
      strobe_seen = -1;
      nvld = 1'b0;
      ndat = '0;
      ok = (int'(i_fill) >= LW) && i_ready && i_rstn && !i_flush;
      if (!i_rstn || i_flush) begin
         expq.delete();
         strobe_idx = 0;
         rcv_col    = 0;
         model_row  = 0;
         run        = 0;
         dphase     = 0;
         chk("reset_outputs", {o_rd, o_valid, o_busy, o_sol, o_eol, o_sof, o_eof, o_col, o_row, o_data}, '0);
      end else begin
         if (o_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("latency", cyc, e.due);
               chk("data", o_data, e.dat);
               chk("col", o_col, e.col);
               chk("row", o_row, e.row);
               chk("sol", o_sol, e.col == 0);
               chk("eol", o_eol, e.col == LW - 1);
               chk("sof", o_sof, (e.col == 0) && (e.row == 0));
               chk("eof", o_eof, (e.col == LW - 1) && (e.row == ROWS - 1));
            end
         end
         while (expq.size() > 0 && expq[0].due < cyc) begin
            chk("missing_valid", 0, 1);
            void'(expq.pop_front());
         end
         if (o_rd) begin
            if (run == 0) chk("rd_rise_allowed", ok, 1);
            chk("busy_in_burst", o_busy, 1);
            run++;
            strobe_seen = strobe_idx;
            strobes_total++;
            if (fifo.size() == 0) begin
               chk("read_on_empty", 1, 0);
            end else begin
               ndat = fifo.pop_front();
               if (strobe_idx != withhold_idx) begin
                  nvld = 1'b1;
                  expq.push_back('{dat: ndat, col: rcv_col, row: model_row, due: cyc + 2});
                  rcv_col++;
               end
            end
            if (strobe_idx == LW - 1) begin
               strobe_idx = 0;
               rcv_col    = 0;
               model_row  = (model_row + 1) % ROWS;
            end else begin
               strobe_idx++;
            end
         end else if (run > 0) begin
            chk("burst_len", run, LW);
            run = 0;
            bursts++;
            dphase = 1;
         end
         if (dphase == 1 || dphase == 2) chk("busy_drain", o_busy, 1);
         else if (dphase == 3)           chk("busy_after_drain", o_busy, 0);
         if (dphase > 0) dphase = (dphase == 3) ? 0 : dphase + 1;
      end
      i_valid  = pend_vld;
      i_data   = pend_dat;
      pend_vld = nvld;
      pend_dat = ndat;
      i_fill   = FW'(fifo.size());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         if (fifo.size() < 31) fifo.push_back(DW'($urandom));
      end
      i_fill = FW'(fifo.size());
   endtask

   task automatic wait_bursts(input int n);
      int target;
      target = bursts + n;
      for (int i = 0; i < 300 && bursts < target; i++) tick();
      chk("burst_timeout", bursts, target);
   endtask

   task automatic wait_strobe(input int idx);
      int i;
      i = 0;
      do begin
         tick();
         i++;
      end while (strobe_seen != idx && i < 300);
      chk("strobe_timeout", strobe_seen, idx);
   endtask

   task automatic pulse_flush();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
   endtask

   initial begin
      int s0;
      i_rstn = 1'b0;
      idle(3);
      i_rstn = 1'b1;
`ifdef PP_ROW_READER_UNDERRUN_EN
      chk("underrun_reset", o_underrun, 0);
`endif

      // Seven pixels are not a row; the eighth releases exactly one burst.
      i_ready = 1'b1;
      push(7);
      idle(10);
      chk("no_rd_fill7", strobes_total, 0);
      push(1);
      wait_bursts(1);
      idle(4);
      chk("row_done_strobes", strobes_total, LW);
      chk("row_done_queue", expq.size(), 0);

      // Two rows buffered but downstream not ready for 5 cycles.
      i_ready = 1'b0;
      push(16);
      s0 = strobes_total;
      idle(5);
      chk("no_rd_not_ready", strobes_total, s0);
      i_ready = 1'b1;
      wait_bursts(2);
      push(8);
      wait_bursts(1);
      idle(4);
      chk("two_rows_queue", expq.size(), 0);

      // Ready falling mid-burst does not cut the row short.
      push(16);
      wait_strobe(3);
      i_ready = 1'b0;
      wait_bursts(1);
      s0 = strobes_total;
      idle(6);
      chk("ready_gates_next", strobes_total, s0);
      i_ready = 1'b1;
      wait_bursts(1);
      idle(4);

      // Flush in the middle of a burst; next row starts a fresh frame.
      push(8);
      wait_strobe(4);
      pulse_flush();
      push(8);
      wait_bursts(1);
      idle(4);
      chk("after_flush_queue", expq.size(), 0);

      // Last pixel never returns: row still closes and row count advances.
      withhold_idx = LW - 1;
      push(8);
      wait_bursts(1);
      idle(4);
      withhold_idx = -1;
`ifdef PP_ROW_READER_UNDERRUN_EN
      chk("underrun_set", o_underrun, 1);
`endif
      push(8);
      wait_bursts(1);
      idle(4);
`ifdef PP_ROW_READER_UNDERRUN_EN
      chk("underrun_sticky", o_underrun, 1);
`endif
      pulse_flush();
`ifdef PP_ROW_READER_UNDERRUN_EN
      chk("underrun_cleared", o_underrun, 0);
`endif

      // Reset pulse while draining.
      push(8);
      wait_strobe(LW - 1);
      tick();
      i_rstn = 1'b0;
      tick();
      i_rstn = 1'b1;
      idle(3);

      // Randomised traffic: bursty fill, ready toggling, occasional drops and flushes.
      for (int it = 0; it < 40; it++) begin
         push($urandom_range(0, 12));
         i_ready = ($urandom_range(0, 3) != 0);
         withhold_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
         if ($urandom_range(0, 15) == 0) pulse_flush();
         idle($urandom_range(1, 20));
      end
      i_ready = 1'b1;
      withhold_idx = -1;
      idle(80);
      chk("final_queue_empty", expq.size(), 0);
      chk("final_fifo_below_row", fifo.size() < LW, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
